spi_cfg_receiver: RTL
=====================

# spi_cfg_receiver

Chip-side receiver for the FPGA configuration serial link (GRST / REGSEL / SIN / gated serial clock). It oversamples the incoming serial lines on the local system clock, deserializes a slave-select address phase followed by a data phase, and commits each frame into an internal configuration register bank. It also generates a one-cycle write strobe for downstream slaves and provides a registered readback port.

## Interface
Parameters:
- ADDR_W, 5, address (slave-select) field width, sent MSB first
- DATA_W, 30, data field width, sent LSB first
- NUM_REGS, 23, bank depth; valid addresses 0..NUM_REGS-1
- SYNC_STAGES, 2, synchronizer depth on every serial input (min 2)

Ports (one clock; reset asynchronous, active-low):
- SCLK  in  1  system clock; all logic on rising edge
- RST  in  1  asynchronous active-low reset
- SCK  in  1  gated serial clock from FPGA; asynchronous to SCLK
- GRST_IN  in  1  chip reset request from FPGA, active-high
- SIN  in  1  serial data; changes on SCK falling edge
- REGSEL  in  1  1 = address phase, 0 = data phase
- RD_ADDR  in  ADDR_W  readback address
- RD_DATA  out  DATA_W  bank[RD_ADDR], registered; 0 if RD_ADDR >= NUM_REGS
- WR_STB  out  1  one-cycle pulse on successful frame commit
- WR_ADDR  out  ADDR_W  address of last commit, held
- WR_DATA  out  DATA_W  data of last commit, held
- ADDR_ERR  out  1  one-cycle pulse: complete frame with address >= NUM_REGS
- FRAME_ERR  out  1  one-cycle pulse: frame aborted/malformed
- CHIP_RST  out  1  synchronized GRST_IN
- BUSY  out  1  high in ADDR or DATA state

## Operation
- SCK, SIN, REGSEL, GRST_IN each pass through SYNC_STAGES flops (reset 0). SCK rise = sync SCK 1 and previous sync value 0. SIN/REGSEL sampled from their synchronized copies in the same cycle as SCK rise is detected.
- States: IDLE, ADDR, DATA, HOLD.
- IDLE: SCK rise with REGSEL=1 -> ADDR, shift bit in, addr_cnt=1. SCK rise with REGSEL=0 ignored.
- ADDR: each SCK rise with REGSEL=1: addr_sr = {addr_sr[ADDR_W-2:0], SIN}; addr_cnt saturates at ADDR_W. Extra bits keep only the last ADDR_W. REGSEL falls (synced): if addr_cnt < ADDR_W -> FRAME_ERR, IDLE; else -> DATA, data_cnt=0.
- DATA: each SCK rise with REGSEL=0: data_sr[data_cnt] = SIN, data_cnt++. When data_cnt reaches DATA_W: if addr < NUM_REGS, write bank, update WR_ADDR/WR_DATA, pulse WR_STB; else pulse ADDR_ERR, no write. Then -> HOLD. REGSEL rising before DATA_W bits -> FRAME_ERR, restart ADDR with that SCK rise's bit if coincident, else addr_cnt=0.
- HOLD: SCK rises with REGSEL=0 ignored (trailing/idle clocks). REGSEL rise -> ADDR, addr_cnt=0 (first bit on next SCK rise, or same cycle if coincident).
- CHIP_RST=1 (synced GRST_IN high): bank cleared to 0, state -> IDLE, counters/shift regs 0; if state was ADDR/DATA, pulse FRAME_ERR once. No frame accepted while CHIP_RST=1. WR_ADDR/WR_DATA cleared.
- Counter widths: addr_cnt clog2(ADDR_W+1), data_cnt clog2(DATA_W+1); no wrap.

## Timing
- RST low: all outputs 0, bank 0, state IDLE, immediately (async); release synchronous to next SCLK edge.
- SCK edge at pin to detection: SYNC_STAGES+1 SCLK cycles; bit registered on the following edge.
- WR_STB/ADDR_ERR: high exactly one SCLK cycle, the cycle after the DATA_W-th bit is registered; bank and WR_ADDR/WR_DATA valid in that same cycle.
- RD_DATA: 1-cycle latency from RD_ADDR; write and read same address same cycle returns old value.
- SCK high and low each >= SYNC_STAGES+2 SCLK cycles; REGSEL/SIN stable across the SCK rise window. Violations undefined.
- CHIP_RST has priority over any frame event in the same cycle; RST over everything.

## Test plan
- Frame addr=10 (01010), data=35: WR_STB one pulse, WR_ADDR=10, WR_DATA=35, RD_ADDR=10 -> RD_DATA=35 next cycle.
- Back-to-back frames addr 22/data 2 then addr 16/data 100 with 4 idle SCK clocks between: two WR_STB pulses, bank[22]=2, bank[16]=100, idle clocks no effect.
- addr=25, data=7: ADDR_ERR pulse, no WR_STB, bank unchanged, RD_ADDR=25 -> 0.
- REGSEL reasserted after 12 data bits, then full frame addr=3/data=0x3FFFFFFF: one FRAME_ERR, then bank[3]=0x3FFFFFFF.
- GRST_IN high mid-data after bank[10]=35: FRAME_ERR, CHIP_RST=1, bank[10]=0; SCK/REGSEL activity ignored until GRST_IN low.
- RST low mid-frame: all outputs 0 asynchronously; after release, fresh frame addr=1/data=5 commits correctly.

Source files
------------

// File: rtl/spi_cfg_receiver.sv
// spi_cfg_receiver: chip-side receiver for the FPGA configuration serial link.
// Every serial input is oversampled on SCLK. Frames have two phases: an
// address (slave-select) phase, sent MSB first while REGSEL=1, and a data
// phase, sent LSB first while REGSEL=0. Each complete frame is committed
// into an internal register bank. The block also raises a one-cycle write
// strobe and provides a registered readback port.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no frame in progress; wait for an SCK rise with REGSEL=1
// ADDR   | shifting address bits in, MSB first
// DATA   | shifting data bits in, LSB first; commit after DATA_W bits
// HOLD   | frame done; ignore trailing SCK, wait for a REGSEL rise
module spi_cfg_receiver #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 30,
  parameter int NUM_REGS    = 23,
  parameter int SYNC_STAGES = 2
) (
  input  logic              SCLK,
  input  logic              RST,
  input  logic              SCK,
  input  logic              GRST_IN,
  input  logic              SIN,
  input  logic              REGSEL,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              WR_STB,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              ADDR_ERR,
  output logic              FRAME_ERR,
  output logic              CHIP_RST,
  output logic              BUSY
);

  localparam int AC_W = $clog2(ADDR_W + 1);
  localparam int DC_W = $clog2(DATA_W + 1);
  localparam logic [AC_W-1:0]   ADDR_CNT_MAX = AC_W'(ADDR_W);
  localparam logic [DC_W-1:0]   DATA_CNT_MAX = DC_W'(DATA_W);
  localparam logic [ADDR_W:0]   NUM_REGS_C   = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, sin_sync_q, regsel_sync_q, grst_sync_q;
  logic                   sck_prev_q;
  logic                   sck_s, sin_s, regsel_s, chip_rst_s, sck_rise;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_sr_q, addr_sr_d;
  logic [AC_W-1:0]        addr_cnt_q, addr_cnt_d;
  logic [DATA_W-1:0]      data_sr_q, data_sr_d;
  logic [DC_W-1:0]        data_cnt_q, data_cnt_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]      wr_data_q, wr_data_d;
  logic                   wr_stb_q, wr_stb_d;
  logic                   addr_err_q, addr_err_d;
  logic                   frame_err_q, frame_err_d;
  logic [DATA_W-1:0]      rd_data_q;
  logic [DATA_W-1:0]      bank_q [NUM_REGS];
  logic                   bank_we, bank_clr;

  logic [ADDR_W-1:0]      addr_shift;
  logic [ADDR_W-1:0]      addr_first;
  logic [AC_W-1:0]        addr_cnt_inc;
  logic                   addr_ok;

  // Synchronizer chains for all asynchronous serial-link inputs.
  always_ff @(posedge SCLK or negedge RST) begin
    if (!RST) begin
      sck_sync_q    <= '0;
      sin_sync_q    <= '0;
      regsel_sync_q <= '0;
      grst_sync_q   <= '0;
      sck_prev_q    <= 1'b0;
    end else begin
      sck_sync_q    <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
      sin_sync_q    <= {sin_sync_q[SYNC_STAGES-2:0], SIN};
      regsel_sync_q <= {regsel_sync_q[SYNC_STAGES-2:0], REGSEL};
      grst_sync_q   <= {grst_sync_q[SYNC_STAGES-2:0], GRST_IN};
      sck_prev_q    <= sck_s;
    end
  end

  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign sin_s      = sin_sync_q[SYNC_STAGES-1];
  assign regsel_s   = regsel_sync_q[SYNC_STAGES-1];
  assign chip_rst_s = grst_sync_q[SYNC_STAGES-1];
  assign sck_rise   = sck_s & ~sck_prev_q;

  assign addr_shift   = {addr_sr_q[ADDR_W-2:0], sin_s};
  assign addr_first   = {{(ADDR_W-1){1'b0}}, sin_s};
  assign addr_cnt_inc = (addr_cnt_q == ADDR_CNT_MAX) ? addr_cnt_q : addr_cnt_q + AC_W'(1);
  assign addr_ok      = ({1'b0, addr_sr_q} < NUM_REGS_C);

  // State and frame datapath registers.
  always_ff @(posedge SCLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      addr_sr_q   <= '0;
      addr_cnt_q  <= '0;
      data_sr_q   <= '0;
      data_cnt_q  <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_stb_q    <= 1'b0;
      addr_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_sr_q   <= addr_sr_d;
      addr_cnt_q  <= addr_cnt_d;
      data_sr_q   <= data_sr_d;
      data_cnt_q  <= data_cnt_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_stb_q    <= wr_stb_d;
      addr_err_q  <= addr_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state, shift and commit logic; chip reset overrides any frame event.
  always_comb begin
    state_d     = state_q;
    addr_sr_d   = addr_sr_q;
    addr_cnt_d  = addr_cnt_q;
    data_sr_d   = data_sr_q;
    data_cnt_d  = data_cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_stb_d    = 1'b0;
    addr_err_d  = 1'b0;
    frame_err_d = 1'b0;
    bank_we     = 1'b0;
    bank_clr    = 1'b0;

    if (chip_rst_s) begin
      state_d     = S_IDLE;
      addr_sr_d   = '0;
      addr_cnt_d  = '0;
      data_sr_d   = '0;
      data_cnt_d  = '0;
      wr_addr_d   = '0;
      wr_data_d   = '0;
      bank_clr    = 1'b1;
      frame_err_d = (state_q == S_ADDR) || (state_q == S_DATA);
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (sck_rise && regsel_s) begin
            state_d    = S_ADDR;
            addr_sr_d  = addr_first;
            addr_cnt_d = AC_W'(1);
          end
        end

        S_ADDR: begin
          if (regsel_s) begin
            if (sck_rise) begin
              addr_sr_d  = addr_shift;
              addr_cnt_d = addr_cnt_inc;
            end
          end else if (addr_cnt_q < ADDR_CNT_MAX) begin
            // Address phase ended short: drop the frame.
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
            addr_sr_d   = '0;
            addr_cnt_d  = '0;
          end else begin
            state_d    = S_DATA;
            data_sr_d  = '0;
            data_cnt_d = '0;
            if (sck_rise) begin
              data_sr_d[0] = sin_s;
              data_cnt_d   = DC_W'(1);
            end
          end
        end

        S_DATA: begin
          if (data_cnt_q == DATA_CNT_MAX) begin
            state_d = S_HOLD;
            if (addr_ok) begin
              bank_we   = 1'b1;
              wr_stb_d  = 1'b1;
              wr_addr_d = addr_sr_q;
              wr_data_d = data_sr_q;
            end else begin
              addr_err_d = 1'b1;
            end
          end else if (regsel_s) begin
            // New address phase started before the data phase completed.
            frame_err_d = 1'b1;
            state_d     = S_ADDR;
            addr_sr_d   = '0;
            addr_cnt_d  = '0;
            if (sck_rise) begin
              addr_sr_d  = addr_first;
              addr_cnt_d = AC_W'(1);
            end
          end else if (sck_rise) begin
            data_sr_d[data_cnt_q] = sin_s;
            data_cnt_d            = data_cnt_q + DC_W'(1);
          end
        end

        S_HOLD: begin
          if (regsel_s) begin
            state_d    = S_ADDR;
            addr_sr_d  = '0;
            addr_cnt_d = '0;
            if (sck_rise) begin
              addr_sr_d  = addr_first;
              addr_cnt_d = AC_W'(1);
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // Configuration bank: cleared by either reset, written on frame commit.
  always_ff @(posedge SCLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
    end else if (bank_clr) begin
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
    end else if (bank_we) begin
      bank_q[addr_sr_q] <= data_sr_q;
    end
  end

  // Registered readback; out-of-range addresses read as zero.
  always_ff @(posedge SCLK or negedge RST) begin
    if (!RST) begin
      rd_data_q <= '0;
    end else if ({1'b0, RD_ADDR} < NUM_REGS_C) begin
      rd_data_q <= bank_q[RD_ADDR];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign RD_DATA   = rd_data_q;
  assign WR_STB    = wr_stb_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_DATA   = wr_data_q;
  assign ADDR_ERR  = addr_err_q;
  assign FRAME_ERR = frame_err_q;
  assign CHIP_RST  = chip_rst_s;
  assign BUSY      = (state_q == S_ADDR) || (state_q == S_DATA);

endmodule
